// File: rtl/uart_tx_fifo_if.sv
// uart_tx_fifo_if: write-side bus of the buffered UART transmitter.
//   master : the producer (debugger core) drives wr_en/wr_data and
//            observes the FIFO status.
//   slave  : the transmitter accepts wr_en/wr_data and reports
//            full, empty, count (0..FIFO_DEPTH) and the sticky overflow.
interface uart_tx_fifo_if #(
   parameter int FIFO_DEPTH = 16
);
   localparam int CW = $clog2(FIFO_DEPTH) + 1;

   logic          wr_en;
   logic [7:0]    wr_data;
   logic          full;
   logic          empty;
   logic [CW-1:0] count;
   logic          overflow;

   modport master (output wr_en, wr_data, input full, empty, count, overflow);
   modport slave  (input wr_en, wr_data, output full, empty, count, overflow);
endinterface

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: buffered 8N1/8N2 serial transmitter for the host link.
// Bytes written through the bus are queued in a circular FIFO and sent
// LSB first; queued bytes follow each other with no idle gap on txd.
// Ports:
//   clk       rising-edge clock
//   rst       asynchronous active-high reset
//   bus       write strobe/data in, full/empty/count/overflow out
//   txd       registered serial line, idles high
//   tx_busy   high whenever the frame FSM is not idle
//   byte_done one-cycle pulse on the last clock of the final stop bit
module uart_tx_fifo #(
   parameter int CLK_FREQ   = 12500000,
   parameter int BAUD       = 115200,
   parameter int FIFO_DEPTH = 16,
   parameter int STOP_BITS  = 2
) (
   input  logic          clk,
   input  logic          rst,
   uart_tx_fifo_if.slave bus,
   output logic          txd,
   output logic          tx_busy,
   output logic          byte_done
);
   localparam int DIV = (CLK_FREQ + BAUD / 2) / BAUD;
   localparam int AW  = $clog2(FIFO_DEPTH);
   localparam int CW  = AW + 1;
   localparam int TW  = $clog2(DIV) + 1;
   localparam logic [TW-1:0] LAST_TICK = TW'(DIV - 1);
   localparam logic [CW-1:0] DEPTH_CNT = CW'(FIFO_DEPTH);
   localparam logic          STOP_LAST = 1'(STOP_BITS - 1);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   state_t        state, stateNext;
   logic [7:0]    mem [FIFO_DEPTH];
   logic [AW-1:0] wrPtr, rdPtr;
   logic [CW-1:0] count, countNext;
   logic          full, empty, overflow;
   logic [TW-1:0] bitTimer, bitTimerNext;
   logic [2:0]    bitIdx, bitIdxNext;
   logic          stopCnt, stopCntNext;
   logic [7:0]    shiftReg, shiftNext;
   logic          txdNext;
   logic          push, pop, bitEnd;

   assign push   = bus.wr_en && !full;
   assign bitEnd = (bitTimer == LAST_TICK);

   assign bus.full     = full;
   assign bus.empty    = empty;
   assign bus.count    = count;
   assign bus.overflow = overflow;
   assign tx_busy      = (state != IDLE);

   // simultaneous push and pop leave the occupancy unchanged
   always_comb begin
      countNext = count;
      case ({push, pop})
         2'b10:   countNext = count + CW'(1);
         2'b01:   countNext = count - CW'(1);
         default: countNext = count;
      endcase
   end

   // ---- FIFO control: pointers, occupancy, registered flags ----
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wrPtr    <= '0;
         rdPtr    <= '0;
         count    <= '0;
         full     <= 1'b0;
         empty    <= 1'b1;
         overflow <= 1'b0;
      end else begin
         if (push) wrPtr <= wrPtr + AW'(1);
         if (pop)  rdPtr <= rdPtr + AW'(1);
         count <= countNext;
         full  <= (countNext == DEPTH_CNT);
         empty <= (countNext == '0);
         if (bus.wr_en && full) overflow <= 1'b1;
      end
   end

   // ---- FIFO storage (data only, never reset) ----
   always_ff @(posedge clk) begin
      if (push) mem[wrPtr] <= bus.wr_data;
   end

   // ---- frame FSM state register ----
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         bitTimer <= '0;
         bitIdx   <= '0;
         stopCnt  <= 1'b0;
         txd      <= 1'b1;
      end else begin
         state    <= stateNext;
         bitTimer <= bitTimerNext;
         bitIdx   <= bitIdxNext;
         stopCnt  <= stopCntNext;
         txd      <= txdNext;
      end
   end

   always_ff @(posedge clk) begin
      shiftReg <= shiftNext;
   end

   // ---- frame FSM next state; txd is computed one clock ahead so the
   //      line is driven straight from a flop ----
   always_comb begin
      stateNext    = state;
      bitTimerNext = bitEnd ? '0 : bitTimer + TW'(1);
      bitIdxNext   = bitIdx;
      stopCntNext  = stopCnt;
      shiftNext    = shiftReg;
      txdNext      = txd;
      pop          = 1'b0;
      byte_done    = 1'b0;
      case (state)
         IDLE: begin
            txdNext      = 1'b1;
            bitTimerNext = '0;
            // registered count: a byte written this cycle waits one clock
            if (count != '0) begin
               pop       = 1'b1;
               shiftNext = mem[rdPtr];
               stateNext = START;
               txdNext   = 1'b0;
            end
         end
         START: begin
            if (bitEnd) begin
               stateNext  = DATA;
               bitIdxNext = '0;
               txdNext    = shiftReg[0];
            end
         end
         DATA: begin
            if (bitEnd) begin
               shiftNext = {1'b0, shiftReg[7:1]};
               if (bitIdx == 3'd7) begin
                  stateNext   = STOP;
                  stopCntNext = 1'b0;
                  txdNext     = 1'b1;
               end else begin
                  bitIdxNext = bitIdx + 3'd1;
                  txdNext    = shiftReg[1];
               end
            end
         end
         STOP: begin
            txdNext = 1'b1;
            if (bitEnd) begin
               if (stopCnt == STOP_LAST) begin
                  byte_done = 1'b1;
                  // chain straight into the next start bit when data waits
                  if (count != '0) begin
                     pop       = 1'b1;
                     shiftNext = mem[rdPtr];
                     stateNext = START;
                     txdNext   = 1'b0;
                  end else begin
                     stateNext = IDLE;
                  end
               end else begin
                  stopCntNext = 1'b1;
               end
            end
         end
         default: stateNext = IDLE;
      endcase
   end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: scoreboard bench for uart_tx_fifo.
// Instance A uses the default link (115200 baud, 2 stop bits); instance B
// runs 9600 baud with 1 stop bit. Written bytes accepted by the bench's
// FIFO model go into expQ; a line receiver watching txdA decodes each
// frame and pops/compares against expQ independently of the stimulus.
`timescale 1ns/1ps
module tb_uart_tx_fifo;
   localparam int CLK_FREQ = 12500000;
   localparam int BAUD_A   = 115200;
   localparam int BAUD_B   = 9600;
   localparam int DEPTH    = 16;
   localparam int DIV_A    = (CLK_FREQ + BAUD_A / 2) / BAUD_A;
   localparam int DIV_B    = (CLK_FREQ + BAUD_B / 2) / BAUD_B;
   localparam int FRAME_A  = 11 * DIV_A;
   localparam int FRAME_B  = 10 * DIV_B;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   uart_tx_fifo_if #(.FIFO_DEPTH(DEPTH)) busA ();
   uart_tx_fifo_if #(.FIFO_DEPTH(DEPTH)) busB ();
   logic txdA, busyA, doneA, txdB, busyB, doneB;

   uart_tx_fifo #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD_A), .FIFO_DEPTH(DEPTH), .STOP_BITS(2)) dutA (
      .clk(clk), .rst(rst), .bus(busA), .txd(txdA), .tx_busy(busyA), .byte_done(doneA));
   uart_tx_fifo #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD_B), .FIFO_DEPTH(DEPTH), .STOP_BITS(1)) dutB (
      .clk(clk), .rst(rst), .bus(busB), .txd(txdB), .tx_busy(busyB), .byte_done(doneB));

   int errors = 0;
   int checks = 0;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // reference model: FIFO contents and occupancy
   logic [7:0] expQ[$];
   int         modelCount = 0;
   logic       expOvf = 1'b0;
   int         frameStarts[$];
   int         doneCount = 0;
   int         badDone = 0;

   // line receiver on txdA
   bit          inFrame = 0;
   int          off = 0;
   logic        prevTxd = 1'b1;
   logic [10:0] rx;
   always @(negedge clk) begin
      if (rst) begin
         inFrame = 0;
         prevTxd = 1'b1;
      end else begin
         if (!inFrame && prevTxd && !txdA) begin
            inFrame = 1;
            off = 0;
            rx = '0;
            frameStarts.push_back(cyc);
            if (modelCount > 0) modelCount--;
         end else if (inFrame) begin
            off++;
         end
         if (inFrame) begin
            if (off % DIV_A == DIV_A / 2) rx[off / DIV_A] = txdA;
            if (off == FRAME_A - 1) begin
               check("byte_done on last stop clock", doneA, 1'b1);
               doneCount++;
               check("start bit level", rx[0], 1'b0);
               check("stop bit levels", rx[10:9], 2'b11);
               if (expQ.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected frame: got 0x%0h, expected no frame", rx[8:1]);
               end else begin
                  check("frame data", rx[8:1], expQ.pop_front());
               end
               inFrame = 0;
            end else if (doneA) begin
               badDone++;
            end
         end else if (doneA) begin
            badDone++;
         end
         prevTxd = txdA;
      end
   end

   // called just after a falling edge; captured on the next rising edge
   task automatic writeA(input logic [7:0] d);
      busA.wr_en   = 1'b1;
      busA.wr_data = d;
      if (modelCount < DEPTH) begin
         expQ.push_back(d);
         modelCount++;
      end else begin
         expOvf = 1'b1;
      end
      @(negedge clk);
      busA.wr_en = 1'b0;
   endtask

   task automatic drainA(input int budget);
      int g = 0;
      while (busyA && g < budget) begin
         @(negedge clk);
         g++;
      end
      check("transmitter went idle", busyA, 1'b0);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int n, idx, d0, sawLow, doneOff, g;
      logic [9:0] bitsB;
      rst = 1'b1;
      busA.wr_en = 1'b0; busA.wr_data = '0;
      busB.wr_en = 1'b0; busB.wr_data = '0;
      repeat (3) @(negedge clk);
      check("reset txd", txdA, 1'b1);
      check("reset tx_busy", busyA, 1'b0);
      check("reset byte_done", doneA, 1'b0);
      check("reset count", busA.count, 0);
      check("reset empty", busA.empty, 1'b1);
      check("reset full", busA.full, 1'b0);
      check("reset overflow", busA.overflow, 1'b0);
      rst = 1'b0;
      @(negedge clk);

      // single byte: start bit two clocks after the write is presented
      writeA(8'h55);
      check("count after write", busA.count, 1);
      check("txd idle after write edge", txdA, 1'b1);
      @(negedge clk);
      check("txd start bit", txdA, 1'b0);
      check("tx_busy at start", busyA, 1'b1);
      check("count after pop", busA.count, 0);
      n = 0;
      while (busyA && n < FRAME_A + 20) begin
         @(negedge clk);
         n++;
      end
      check("single frame length", n, FRAME_A);
      check("one byte_done", doneCount, 1);

      // burst of three: first byte is popped on the edge accepting the second
      idx = frameStarts.size();
      d0 = doneCount;
      writeA(8'hA5);
      check("burst count 1", busA.count, 1);
      writeA(8'h00);
      check("burst count 2", busA.count, 1);
      writeA(8'hFF);
      check("burst count 3", busA.count, 2);
      drainA(3 * FRAME_A + 20);
      check("burst frames", frameStarts.size() - idx, 3);
      if (frameStarts.size() >= idx + 3) begin
         check("burst gap 1", frameStarts[idx+1] - frameStarts[idx], FRAME_A);
         check("burst gap 2", frameStarts[idx+2] - frameStarts[idx+1], FRAME_A);
         check("burst total", cyc - frameStarts[idx], 3 * FRAME_A);
      end
      check("burst byte_done pulses", doneCount - d0, 3);

      // full / overflow while a frame is in flight
      d0 = doneCount;
      writeA(8'h11);
      @(negedge clk);
      check("busy before fill", busyA, 1'b1);
      for (int i = 0; i < 17; i++) begin
         writeA(8'($urandom));
         if (i == 15) begin
            check("count at full", busA.count, DEPTH);
            check("full flag", busA.full, 1'b1);
            check("no overflow yet", busA.overflow, 1'b0);
         end
      end
      check("count after dropped write", busA.count, DEPTH);
      check("overflow set", busA.overflow, expOvf);
      drainA(17 * FRAME_A + 50);
      check("frames after fill", doneCount - d0, 17);
      check("overflow sticky", busA.overflow, 1'b1);
      check("queue drained", expQ.size(), 0);

      // write on the byte_done clock with one byte waiting
      writeA(8'hC3);
      @(negedge clk);
      writeA(8'($urandom));
      g = 0;
      while (!doneA && g < FRAME_A + 20) begin
         @(negedge clk);
         g++;
      end
      check("reached byte_done", doneA, 1'b1);
      writeA(8'($urandom));
      check("count on write+pop", busA.count, 1);
      check("back-to-back start", txdA, 1'b0);
      check("busy on chain", busyA, 1'b1);
      drainA(2 * FRAME_A + 50);
      check("queue drained after chain", expQ.size(), 0);

      // asynchronous reset during data bit 4 of 0x3C
      writeA(8'h3C);
      writeA(8'hAA);
      writeA(8'h55);
      repeat (DIV_A * 5 + 39) @(negedge clk);
      check("count before reset", busA.count, 2);
      check("bit 4 of 0x3C", txdA, 1'b1);
      #1 rst = 1'b1;
      expQ.delete();
      modelCount = 0;
      expOvf = 1'b0;
      #1;
      check("async reset txd", txdA, 1'b1);
      check("async reset count", busA.count, 0);
      check("async reset busy", busyA, 1'b0);
      check("async reset empty", busA.empty, 1'b1);
      check("async reset overflow", busA.overflow, 1'b0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      d0 = doneCount;
      sawLow = 0;
      for (int i = 0; i < 3 * FRAME_A; i++) begin
         @(negedge clk);
         if (!txdA) sawLow++;
      end
      check("line quiet after reset", sawLow, 0);
      check("no frames after reset", doneCount - d0, 0);
      writeA(8'h5A);
      @(negedge clk);
      drainA(FRAME_A + 20);
      check("frame after reset recovery", doneCount - d0, 1);

      // 9600 baud, one stop bit
      busB.wr_en = 1'b1;
      busB.wr_data = 8'h80;
      @(negedge clk);
      busB.wr_en = 1'b0;
      g = 0;
      while (txdB && g < 10) begin
         @(negedge clk);
         g++;
      end
      check("B start latency", g, 1);
      bitsB = '0;
      doneOff = -1;
      for (int o = 0; o < FRAME_B + 4; o++) begin
         if (o % DIV_B == DIV_B / 2 && o / DIV_B < 10) bitsB[o / DIV_B] = txdB;
         if (doneB && doneOff < 0) doneOff = o;
         if (o == FRAME_B) check("B idle after frame", busyB, 1'b0);
         @(negedge clk);
      end
      check("B frame bits", bitsB, {1'b1, 8'h80, 1'b0});
      check("B byte_done offset", doneOff, FRAME_B - 1);

      check("no stray byte_done", badDone, 0);
      check("scoreboard empty", expQ.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
